// File: rtl/bram_asym_fifo_ctrl.sv
// Sequencer for an external asymmetric block RAM used as a FIFO: wide write port, narrow
// 1-cycle registered read port, 2-entry prefetch buffer. Define BRAM_ASYM_FIFO_LEVEL_EN for level.
module bram_asym_fifo_ctrl #(
    parameter int unsigned WR_WIDTH = 32,
    parameter int unsigned RD_WIDTH = 8,
    parameter int unsigned WA_BITS  = 10,
    localparam int unsigned R       = WR_WIDTH / RD_WIDTH,
    localparam int unsigned RA_BITS = WA_BITS + $clog2(R)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [WR_WIDTH-1:0] s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [RD_WIDTH-1:0] m_data,
    output logic [RA_BITS:0]    level,
    output logic                ram_wce,
    output logic [WA_BITS-1:0]  ram_wa,
    output logic [WR_WIDTH-1:0] ram_wd,
    output logic                ram_rce,
    output logic [RA_BITS-1:0]  ram_ra,
    input  logic [RD_WIDTH-1:0] ram_rq
);

    localparam int unsigned LOG2R   = $clog2(R);
    localparam int unsigned PW      = RA_BITS + 1;
    localparam int unsigned WPW     = WA_BITS + 1;
    localparam int unsigned DEPTH_N = 32'(1) << RA_BITS;

    logic [WA_BITS:0]    wp;
    logic [RA_BITS:0]    rp;
    logic                inflight;
    logic [1:0]          buf_count;
    logic [RD_WIDTH-1:0] buf_head;
    logic [RD_WIDTH-1:0] buf_tail;
    logic                run;

    logic [RA_BITS:0]    ram_occ;
    logic [RA_BITS:0]    ram_free;
    logic [2:0]          credit;
    logic [1:0]          kept;
    logic                push;
    logic                pop;
    logic                issue;

    // Occupancy in narrow units; the extra pointer bit disambiguates full from empty.
    assign ram_occ  = (PW'(wp) << LOG2R) - rp;
    assign ram_free = PW'(DEPTH_N) - ram_occ;

    assign s_ready  = run & (ram_free >= PW'(R));
    assign push     = s_valid & s_ready;
    assign m_valid  = (buf_count != 2'd0);
    assign m_data   = buf_head;
    assign pop      = m_valid & m_ready;

    // Never let buffered plus in-flight units exceed the two buffer slots.
    assign credit   = 3'(buf_count) + 3'(inflight);
    assign issue    = (ram_occ != '0) & (credit < (3'd2 + 3'(pop)));
    assign kept     = buf_count - 2'(pop);

    assign ram_wce  = push;
    assign ram_wa   = wp[WA_BITS-1:0];
    assign ram_wd   = s_data;
    assign ram_rce  = issue;
    assign ram_ra   = rp[RA_BITS-1:0];

    // Pointers and the reset-release gate for s_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            run <= 1'b0;
        end else begin
            wp  <= wp + WPW'(push);
            rp  <= rp + PW'(issue);
            run <= 1'b1;
        end
    end

    // Prefetch buffer: head shifts on pop, returning read data lands behind what is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight  <= 1'b0;
            buf_count <= 2'd0;
            buf_head  <= '0;
            buf_tail  <= '0;
        end else begin
            inflight  <= issue;
            buf_count <= kept + 2'(inflight);
            if (pop) begin
                buf_head <= buf_tail;
            end
            if (inflight) begin
                if (kept == 2'd0) begin
                    buf_head <= ram_rq;
                end else begin
                    buf_tail <= ram_rq;
                end
            end
        end
    end

`ifdef BRAM_ASYM_FIFO_LEVEL_EN
    // Units held anywhere in the FIFO: RAM, in flight, and buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else begin
            level <= level + (push ? PW'(R) : PW'(0)) - PW'(pop);
        end
    end
`else
    assign level = '0;
`endif

endmodule

// File: tb/tb_bram_asym_fifo_ctrl.sv
// Directed bench for bram_asym_fifo_ctrl with a behavioural asymmetric RAM model.
// Level expectations follow BRAM_ASYM_FIFO_LEVEL_EN (zero when undefined).
module tb_bram_asym_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic [12:0] level;
    logic        ram_wce;
    logic [9:0]  ram_wa;
    logic [31:0] ram_wd;
    logic        ram_rce;
    logic [11:0] ram_ra;
    logic [7:0]  ram_rq;

    int total = 0;
    int bad = 0;

    logic [7:0] mem [0:4095];

    always #5 clk = ~clk;

    bram_asym_fifo_ctrl #(.WR_WIDTH(32), .RD_WIDTH(8), .WA_BITS(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .level(level),
        .ram_wce(ram_wce), .ram_wa(ram_wa), .ram_wd(ram_wd),
        .ram_rce(ram_rce), .ram_ra(ram_ra), .ram_rq(ram_rq)
    );

    // Asymmetric RAM: lane k of a wide word lives at narrow address {wa, k}.
    always @(posedge clk) begin
        if (ram_wce) begin
            for (int k = 0; k < 4; k++) mem[{ram_wa, 2'(k)}] <= ram_wd[8*k +: 8];
        end
        if (ram_rce) ram_rq <= mem[ram_ra];
    end

    function automatic logic [7:0] exp_byte(input int n);
        return 8'(n * 7 + 3);
    endfunction

    function automatic logic [31:0] mk_word(input int w);
        return {exp_byte(4*w+3), exp_byte(4*w+2), exp_byte(4*w+1), exp_byte(4*w)};
    endfunction

    function automatic logic [12:0] lvl(input int v);
`ifdef BRAM_ASYM_FIFO_LEVEL_EN
        return 13'(v);
`else
        return 13'(v * 0);
`endif
    endfunction

    task automatic do_reset;
        s_valid = 1'b0;
        m_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        s_valid = 1'b1;
        s_data = 32'hDEADBEEF;
        m_ready = 1'b1;
        repeat (2) @(posedge clk); #2;
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready got=%0h want=0", s_ready); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%0h want=0", m_valid); end
        total++; if (m_data !== 8'h00) begin bad++; $display("FAIL rst_m_data got=%0h want=0", m_data); end
        total++; if (level !== 13'd0) begin bad++; $display("FAIL rst_level got=%0d want=0", level); end
        total++; if (ram_wce !== 1'b0) begin bad++; $display("FAIL rst_ram_wce got=%0h want=0", ram_wce); end
        total++; if (ram_rce !== 1'b0) begin bad++; $display("FAIL rst_ram_rce got=%0h want=0", ram_rce); end
        total++; if (ram_wa !== 10'd0) begin bad++; $display("FAIL rst_ram_wa got=%0h want=0", ram_wa); end
        total++; if (ram_ra !== 12'd0) begin bad++; $display("FAIL rst_ram_ra got=%0h want=0", ram_ra); end
        s_valid = 1'b0;
        m_ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #2;
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rel_s_ready got=%0h want=1", s_ready); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rel_m_valid got=%0h want=0", m_valid); end
    endtask

    task automatic test_single_word;
        logic [31:0] w = 32'h44332211;
        do_reset;
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data = w;
        #1;
        total++; if (ram_wce !== 1'b1) begin bad++; $display("FAIL sw_wce got=%0h want=1", ram_wce); end
        total++; if (ram_wa !== 10'd0) begin bad++; $display("FAIL sw_wa got=%0h want=0", ram_wa); end
        total++; if (ram_wd !== w) begin bad++; $display("FAIL sw_wd got=%0h want=%0h", ram_wd, w); end
        @(posedge clk); #2;
        s_valid = 1'b0;
        #1;
        total++; if (ram_rce !== 1'b1) begin bad++; $display("FAIL sw_rce_e1 got=%0h want=1", ram_rce); end
        total++; if (ram_ra !== 12'd0) begin bad++; $display("FAIL sw_ra_e1 got=%0h want=0", ram_ra); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL sw_mv_e1 got=%0h want=0", m_valid); end
        total++; if (level !== lvl(4)) begin bad++; $display("FAIL sw_level_e1 got=%0d want=%0d", level, lvl(4)); end
        @(posedge clk); #2;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL sw_mv_e2 got=%0h want=0", m_valid); end
        total++; if (ram_ra !== 12'd1) begin bad++; $display("FAIL sw_ra_e2 got=%0h want=1", ram_ra); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL sw_mv_%0d got=%0h want=1", i, m_valid); end
            total++; if (m_data !== 8'(w >> (8*i))) begin bad++; $display("FAIL sw_data_%0d got=%0h want=%0h", i, m_data, 8'(w >> (8*i))); end
            total++; if (level !== lvl(4-i)) begin bad++; $display("FAIL sw_level_%0d got=%0d want=%0d", i, level, lvl(4-i)); end
        end
        @(posedge clk); #2;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL sw_mv_end got=%0h want=0", m_valid); end
        total++; if (level !== lvl(0)) begin bad++; $display("FAIL sw_level_end got=%0d want=0", level); end
        total++; if (ram_rce !== 1'b0) begin bad++; $display("FAIL sw_rce_end got=%0h want=0", ram_rce); end
    endtask

    task automatic test_fill;
        int stalls = 0;
        do_reset;
        for (int i = 0; i < 1024; i++) begin
            s_valid = 1'b1;
            s_data = mk_word(i);
            #1;
            if (!s_ready) stalls++;
            @(posedge clk); #2;
        end
        s_valid = 1'b0;
        repeat (2) @(posedge clk); #2;
        total++; if (stalls != 0) begin bad++; $display("FAIL fill_stalls got=%0d want=0", stalls); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL fill_s_ready got=%0h want=0", s_ready); end
        total++; if (level !== lvl(4096)) begin bad++; $display("FAIL fill_level got=%0d want=%0d", level, lvl(4096)); end
        total++; if (ram_rce !== 1'b0) begin bad++; $display("FAIL fill_rce got=%0h want=0", ram_rce); end
        total++; if (m_data !== exp_byte(0)) begin bad++; $display("FAIL fill_head got=%0h want=%0h", m_data, exp_byte(0)); end
        m_ready = 1'b1;
        #1;
        total++; if (ram_rce !== 1'b1) begin bad++; $display("FAIL fill_refill0 got=%0h want=1", ram_rce); end
        @(posedge clk); #2;
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL fill_one_pop_ready got=%0h want=0", s_ready); end
        total++; if (m_data !== exp_byte(1)) begin bad++; $display("FAIL fill_pop1 got=%0h want=%0h", m_data, exp_byte(1)); end
        @(posedge clk); #2;
        m_ready = 1'b0;
        #1;
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL fill_two_pop_ready got=%0h want=1", s_ready); end
        total++; if (level !== lvl(4094)) begin bad++; $display("FAIL fill_level2 got=%0d want=%0d", level, lvl(4094)); end
        s_valid = 1'b1;
        s_data = mk_word(1024);
        #1;
        total++; if (ram_wce !== 1'b1) begin bad++; $display("FAIL fill_w1025_wce got=%0h want=1", ram_wce); end
        total++; if (ram_wa !== 10'd0) begin bad++; $display("FAIL fill_w1025_wa got=%0h want=0", ram_wa); end
        @(posedge clk); #2;
        s_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        int pushed = 0;
        int popped = 0;
        int cyc = 0;
        logic [15:0] lf = 16'hACE1;
        do_reset;
        while (popped < 256 && cyc < 3000) begin
            s_valid = (pushed < 64);
            s_data = mk_word(pushed);
            lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
            m_ready = lf[0];
            #1;
            if (s_valid && s_ready) pushed++;
            if (m_valid && m_ready) begin
                total++; if (m_data !== exp_byte(popped)) begin bad++; $display("FAIL bp_data_%0d got=%0h want=%0h", popped, m_data, exp_byte(popped)); end
                popped++;
            end
            @(posedge clk); #2;
            cyc++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        total++; if (popped != 256) begin bad++; $display("FAIL bp_count got=%0d want=256", popped); end
        repeat (4) @(posedge clk); #2;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL bp_extra_valid got=%0h want=0", m_valid); end
        total++; if (level !== lvl(0)) begin bad++; $display("FAIL bp_level got=%0d want=0", level); end
        m_ready = 1'b0;
    endtask

    task automatic test_wrap;
        int pushed = 0;
        int popped = 0;
        int cyc = 0;
        int last_wa = -1;
        int last_ra = -1;
        bit wa_wrap = 1'b0;
        bit ra_wrap = 1'b0;
        m_ready = 1'b1;
        while (popped < 12000 && cyc < 20000) begin
            s_valid = (pushed < 3000);
            s_data = mk_word(pushed);
            #1;
            if (s_valid && s_ready) begin
                if (last_wa >= 0) begin
                    total++; if (int'(ram_wa) != (last_wa + 1) % 1024) begin bad++; $display("FAIL wrap_wa got=%0d want=%0d", ram_wa, (last_wa + 1) % 1024); end
                end
                if (last_wa == 1023 && ram_wa == 10'd0) wa_wrap = 1'b1;
                last_wa = int'(ram_wa);
                pushed++;
            end
            if (ram_rce) begin
                if (last_ra >= 0) begin
                    total++; if (int'(ram_ra) != (last_ra + 1) % 4096) begin bad++; $display("FAIL wrap_ra got=%0d want=%0d", ram_ra, (last_ra + 1) % 4096); end
                end
                if (last_ra == 4095 && ram_ra == 12'd0) ra_wrap = 1'b1;
                last_ra = int'(ram_ra);
            end
            if (m_valid && m_ready) begin
                total++; if (m_data !== exp_byte(popped)) begin bad++; $display("FAIL wrap_data_%0d got=%0h want=%0h", popped, m_data, exp_byte(popped)); end
                popped++;
            end
            @(posedge clk); #2;
            cyc++;
        end
        s_valid = 1'b0;
        total++; if (popped != 12000) begin bad++; $display("FAIL wrap_count got=%0d want=12000", popped); end
        total++; if (wa_wrap !== 1'b1) begin bad++; $display("FAIL wrap_wa_seen got=%0d want=1", wa_wrap); end
        total++; if (ra_wrap !== 1'b1) begin bad++; $display("FAIL wrap_ra_seen got=%0d want=1", ra_wrap); end
        repeat (3) @(posedge clk); #2;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL wrap_end_valid got=%0h want=0", m_valid); end
        m_ready = 1'b0;
    endtask

    task automatic test_mid_reset;
        logic [31:0] w = mk_word(100);
        do_reset;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data = mk_word(i);
            @(posedge clk); #2;
        end
        s_valid = 1'b0;
        repeat (3) @(posedge clk); #2;
        total++; if (level !== lvl(12)) begin bad++; $display("FAIL mr_level12 got=%0d want=%0d", level, lvl(12)); end
        m_ready = 1'b1;
        repeat (2) @(posedge clk); #2;
        m_ready = 1'b0;
        total++; if (level !== lvl(10)) begin bad++; $display("FAIL mr_level10 got=%0d want=%0d", level, lvl(10)); end
        total++; if (m_data !== exp_byte(2)) begin bad++; $display("FAIL mr_head got=%0h want=%0h", m_data, exp_byte(2)); end
        rst_n = 1'b0;
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mr_now_valid got=%0h want=0", m_valid); end
        total++; if (level !== 13'd0) begin bad++; $display("FAIL mr_now_level got=%0d want=0", level); end
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL mr_rel_ready got=%0h want=1", s_ready); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mr_rel_valid got=%0h want=0", m_valid); end
        @(posedge clk); #2;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mr_stale_valid got=%0h want=0", m_valid); end
        s_valid = 1'b1;
        s_data = w;
        m_ready = 1'b1;
        #1;
        total++; if (ram_wa !== 10'd0) begin bad++; $display("FAIL mr_wa got=%0h want=0", ram_wa); end
        @(posedge clk); #2;
        s_valid = 1'b0;
        @(posedge clk); #2;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mr_lat_valid got=%0h want=0", m_valid); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL mr_mv_%0d got=%0h want=1", i, m_valid); end
            total++; if (m_data !== 8'(w >> (8*i))) begin bad++; $display("FAIL mr_data_%0d got=%0h want=%0h", i, m_data, 8'(w >> (8*i))); end
        end
        @(posedge clk); #2;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mr_end_valid got=%0h want=0", m_valid); end
        m_ready = 1'b0;
    endtask

    initial begin
        #1;
        test_reset;
        test_single_word;
        test_fill;
        test_backpressure;
        test_wrap;
        test_mid_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
